// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared constants and types for the data memory arbiter.
package data_mem_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int DEPTH = 256;
  localparam int REQ_CORE = 0;
  localparam int REQ_DMA = 1;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin picker with a lock that is capped at MAX_BURST
// consecutive grants while the other requester is waiting.
module rr_arbiter2 import data_mem_pkg::*; #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  output logic [1:0] gnt_o
);
  localparam int CW = $clog2(MAX_BURST + 1);
  state_e state_q;
  logic last_q;
  logic [CW-1:0] cnt_q;
  logic own_v, own, expired, win;
  always_comb begin
    own_v = state_q != IDLE;
    own = state_q == OWN1;
    expired = cnt_q >= CW'(MAX_BURST) && req_i[~own];
    // owner always equals last, so ~last covers both plain round-robin and burst expiry
    win = &req_i ? ((own_v && !expired) ? own : ~last_q) : req_i[1];
    gnt_o = (rst_n && |req_i) ? (win ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      cnt_q <= '0;
    end else if (|req_i) begin
      last_q <= win;
      state_q <= lock_i[win] ? (win ? OWN1 : OWN0) : IDLE;
      cnt_q <= !lock_i[win] ? '0 :
               (own_v && own == win) ? (cnt_q == CW'(MAX_BURST) ? cnt_q : cnt_q + 1'b1) :
               CW'(1);
    end else begin
      state_q <= IDLE;
      cnt_q <= '0;
    end
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: arbitrates core and DMA access to the single-port data memory,
// drives the memory port and returns registered read data / range errors.
module data_mem_arbiter import data_mem_pkg::*; #(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [1:0]        lock,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic any, sel, in_rng;
  logic [ADDR_W-1:0] a;
  logic [1:0] rvalid_q, err_q;
  logic [DATA_W-1:0] rdata_q;
  rr_arbiter2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .gnt_o(gnt)
  );
  always_comb begin
    any = |gnt;
    sel = gnt[REQ_DMA];
    a = sel ? addr1 : addr0;
    in_rng = a < ADDR_W'(DEPTH);
    mem_addr = any ? a : '0;
    mem_wdata = any ? (sel ? wdata1 : wdata0) : '0;
    mem_we = any && in_rng && we[sel];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      err_q <= '0;
      rdata_q <= '0;
    end else begin
      rvalid_q <= (any && in_rng && !we[sel]) ? gnt : 2'b00;
      err_q <= (any && !in_rng) ? gnt : 2'b00;
      if (any && !we[sel]) rdata_q <= in_rng ? mem_rdata : '0;
    end
  end
  assign rvalid = rvalid_q;
  assign err = err_q;
  assign rdata = rdata_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed plus random stimulus against an integer-level
// arbitration model and a shadow copy of the memory.
module tb_data_mem_arbiter;
  localparam int MAXB = 4;
  logic clk = 1'b0, rst_n = 1'b0, init = 1'b1;
  logic [1:0] req = '0, we = '0, lock = '0;
  logic [14:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [1:0] gnt, rvalid, err;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [14:0] mem_addr;
  logic mem_we;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int n_chk = 0, n_bad = 0;
  int owner = -1, run = 0, last_w = 1;

  data_mem_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .lock(lock), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .err(err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pre(input int i);
    return (32'(i) * 32'h01010101) ^ 32'h5A00_00C3;
  endfunction

  assign mem_rdata = (mem_addr < 15'd256) ? mem[mem_addr[7:0]] : 32'h0;
  always @(posedge clk) begin
    if (init) for (int i = 0; i < 256; i++) mem[i] <= pre(i);
    else if (mem_we && mem_addr < 15'd256) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner by the arbitration rules: a locked owner keeps the memory unless it has
  // already had MAXB consecutive grants while the other side waits.
  function automatic int pick(input logic [1:0] r);
    if (r == 2'b00) return -1;
    if (r != 2'b11) return r[1] ? 1 : 0;
    if (owner >= 0 && run < MAXB) return owner;
    return 1 - last_w;
  endfunction

  task automatic model_reset();
    owner = -1;
    run = 0;
    last_w = 1;
  endtask

  task automatic step(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                      input logic [14:0] a0, input logic [14:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    int pw;
    logic [14:0] a;
    logic [31:0] d, erd;
    logic inr, wn, rd;
    logic [1:0] eg, erv, eer;
    req = r; we = w; lock = l; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    #2;
    pw = pick(r);
    a = (pw == 1) ? a1 : a0;
    d = (pw == 1) ? d1 : d0;
    inr = a < 15'd256;
    wn = pw >= 0 && ((pw == 1) ? w[1] : w[0]);
    eg = (pw < 0) ? 2'b00 : ((pw == 1) ? 2'b10 : 2'b01);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("mem_we", 32'(mem_we), 32'(wn && inr));
    chk("mem_addr", 32'(mem_addr), (pw < 0) ? 32'h0 : 32'(a));
    if (wn) chk("mem_wdata", mem_wdata, d);
    rd = pw >= 0 && !wn;
    erv = (rd && inr) ? eg : 2'b00;
    eer = (pw >= 0 && !inr) ? eg : 2'b00;
    erd = inr ? ref_mem[a[7:0]] : 32'h0;
    if (wn && inr) ref_mem[a[7:0]] = d;
    if (pw < 0) begin
      owner = -1;
      run = 0;
    end else begin
      if (l[pw]) begin
        run = (owner == pw) ? run + 1 : 1;
        owner = pw;
      end else begin
        owner = -1;
        run = 0;
      end
      last_w = pw;
    end
    @(posedge clk);
    #1;
    chk("rvalid", 32'(rvalid), 32'(erv));
    chk("err", 32'(err), 32'(eer));
    if (rd) chk("rdata", rdata, erd);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = pre(i);
    req = 2'b11;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt_hold", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    init = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(2'b11, 2'b00, 2'b00, 15'd1, 15'd2, 0, 0);
    for (int i = 0; i < 6; i++) step(2'b11, 2'b00, 2'b00, 15'(10 + i), 15'(20 + i), 0, 0);
    step(2'b01, 2'b00, 2'b00, 15'd3, 15'd0, 0, 0);
    for (int i = 0; i < 10; i++) step(2'b11, 2'b00, 2'b10, 15'(30 + i), 15'(40 + i), 0, 0);
    step(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    step(2'b01, 2'b01, 2'b00, 15'd5, 15'd0, 32'hDEADBEEF, 0);
    step(2'b10, 2'b00, 2'b00, 15'd0, 15'd5, 0, 0);
    chk("wr_then_rd", rdata, 32'hDEADBEEF);
    step(2'b01, 2'b01, 2'b00, 15'd300, 15'd0, 32'h12345678, 0);
    step(2'b01, 2'b00, 2'b00, 15'd300, 15'd0, 0, 0);
    step(2'b10, 2'b00, 2'b00, 15'd0, 15'd44, 0, 0);
    chk("oor_alias", rdata, pre(44));
    // read in flight when reset hits: its response must never appear
    req = 2'b01; we = 2'b00; lock = 2'b00; addr0 = 15'd7;
    #2;
    chk("midrst_gnt", 32'(gnt), 32'h1);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("midrst_rvalid", 32'(rvalid), 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    step(2'b11, 2'b00, 2'b00, 15'd8, 15'd9, 0, 0);
    for (int i = 0; i < 300; i++) begin
      logic [14:0] ra0, ra1;
      ra0 = ($urandom_range(0, 7) == 0) ? 15'(256 + $urandom_range(0, 200)) : 15'($urandom_range(0, 255));
      ra1 = ($urandom_range(0, 7) == 0) ? 15'(256 + $urandom_range(0, 200)) : 15'($urandom_range(0, 255));
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ra0, ra1, $urandom, $urandom);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
